// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   arb_state_t : arbiter sequencing states
//   arb_owner_t : which requester owns the transaction in flight
//   MEM_ADDR_W / MEM_DATA_W : default memory address / data widths
//   sat_inc4()  : 4-bit saturating increment used by the starvation counter
package cpu_mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_EXT  = 1'b1
    } arb_owner_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        if (value == 4'hF) begin
            return 4'hF;
        end else begin
            return value + 4'd1;
        end
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the
// single-port memory.
//   p_*   : pipeline memory-stage request/response (level request, done pulse)
//   e_*   : external loader/debug request/response (same protocol)
//   stall : pipeline freeze
//   mem_* : memory strobe, write enable, address, write/read data
// Modports: slave = arbiter view, master = requesters + memory view.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = cpu_mem_pkg::MEM_ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::MEM_DATA_W
) ();

    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_done;
    logic              stall;

    logic              e_req;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [DATA_W-1:0] e_rdata;
    logic              e_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_done, stall,
        input  e_req, e_we, e_addr, e_wdata,
        output e_rdata, e_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_done, stall,
        output e_req, e_we, e_addr, e_wdata,
        input  e_rdata, e_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the pipeline memory stage
// and the external loader/debug port. The pipeline has fixed priority, but
// after STARVE_LIMIT consecutive pipeline grants with the external port
// waiting, the external port is granted once. One transaction is in flight
// at a time: IDLE (grant + latch) -> ISSUE (mem_en) -> WAIT (latency) ->
// DONE (done pulse).
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : data_memory_arbiter_if.slave (requesters, stall, memory port)
module data_memory_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);

    // WAIT counts down from LATENCY-1 so read data is sampled exactly
    // MEM_LATENCY cycles after the ISSUE cycle.
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    arb_owner_t        owner_r;
    arb_owner_t        grant_owner_s;
    logic              grant_s;
    logic              pipe_wins_s;
    logic              rd_capture_s;

    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic [2:0]        lat_cnt_r;
    logic [3:0]        starve_cnt_r;
    logic [3:0]        starve_next_s;

    logic              mem_en_r;
    logic              p_done_r;
    logic              e_done_r;
    logic [DATA_W-1:0] p_rdata_r;
    logic [DATA_W-1:0] e_rdata_r;

    // Pipeline wins unless the external port has reached its starvation limit.
    always_comb begin
        pipe_wins_s = 1'b0;
        if (bus.p_req && !((starve_cnt_r == STARVE_MAX) && bus.e_req)) begin
            pipe_wins_s = 1'b1;
        end else begin
            pipe_wins_s = 1'b0;
        end
    end

    // Next-state and grant decode; requests only matter in IDLE.
    always_comb begin
        next_state_s  = state_r;
        grant_s       = 1'b0;
        grant_owner_s = OWN_PIPE;
        case (state_r)
            IDLE: begin
                if (bus.p_req || bus.e_req) begin
                    grant_s       = 1'b1;
                    grant_owner_s = pipe_wins_s ? OWN_PIPE : OWN_EXT;
                    next_state_s  = ISSUE;
                end else begin
                    next_state_s  = IDLE;
                end
            end
            ISSUE: begin
                next_state_s = WAIT;
            end
            WAIT: begin
                if (lat_cnt_r == 3'd0) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Starvation count: only tracks back-to-back pipeline wins while the
    // external port is actually waiting; any idle moment without e_req resets it.
    always_comb begin
        starve_next_s = starve_cnt_r;
        if (state_r != IDLE) begin
            starve_next_s = starve_cnt_r;
        end else if (!bus.e_req) begin
            starve_next_s = 4'd0;
        end else if (grant_owner_s == OWN_PIPE) begin
            starve_next_s = sat_inc4(starve_cnt_r);
        end else begin
            starve_next_s = 4'd0;
        end
    end

    // Read data is captured on the last WAIT cycle; writes leave rdata alone.
    always_comb begin
        rd_capture_s = 1'b0;
        if ((state_r == WAIT) && (lat_cnt_r == 3'd0) && !we_r) begin
            rd_capture_s = 1'b1;
        end else begin
            rd_capture_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Transaction fields latched at grant; they double as the memory bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= OWN_PIPE;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (grant_s) begin
            owner_r <= grant_owner_s;
            if (grant_owner_s == OWN_EXT) begin
                we_r    <= bus.e_we;
                addr_r  <= bus.e_addr;
                wdata_r <= bus.e_wdata;
            end else begin
                we_r    <= bus.p_we;
                addr_r  <= bus.p_addr;
                wdata_r <= bus.p_wdata;
            end
        end
    end

    // Latency and starvation counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt_r    <= 3'd0;
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_next_s;
            if (state_r == ISSUE) begin
                lat_cnt_r <= LAT_LOAD;
            end else if ((state_r == WAIT) && (lat_cnt_r != 3'd0)) begin
                lat_cnt_r <= lat_cnt_r - 3'd1;
            end
        end
    end

    // Registered strobes, done pulses and per-owner read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_r  <= 1'b0;
            p_done_r  <= 1'b0;
            e_done_r  <= 1'b0;
            p_rdata_r <= '0;
            e_rdata_r <= '0;
        end else begin
            mem_en_r <= (next_state_s == ISSUE);
            p_done_r <= (next_state_s == DONE) && (owner_r == OWN_PIPE);
            e_done_r <= (next_state_s == DONE) && (owner_r == OWN_EXT);
            if (rd_capture_s && (owner_r == OWN_PIPE)) begin
                p_rdata_r <= bus.mem_rdata;
            end
            if (rd_capture_s && (owner_r == OWN_EXT)) begin
                e_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.p_done    = p_done_r;
    assign bus.e_done    = e_done_r;
    assign bus.p_rdata   = p_rdata_r;
    assign bus.e_rdata   = e_rdata_r;
    // Freeze the pipeline for as long as its request is outstanding.
    assign bus.stall     = bus.p_req & ~p_done_r;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter. Instance A (latency 1, starve limit 2)
// is shadowed every cycle by a timestamp-based reference model; instance B
// (latency 3) covers the longer-latency read timing.
module tb_data_memory_arbiter;
    import cpu_mem_pkg::*;

    localparam int LAT_A = 1;
    localparam int LIM_A = 2;
    localparam int LAT_B = 3;
    localparam int LIM_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;
    logic mem_load;

    data_memory_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
    data_memory_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

    data_memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT_A), .STARVE_LIMIT(LIM_A))
        dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
    data_memory_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT_B), .STARVE_LIMIT(LIM_B))
        dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        if (i == 64)       return 16'hBEEF;
        else if (i == 255) return 16'h5A5A;
        else               return 16'hA500 | 16'(i);
    endfunction

    // ---------------- memory responders (exact-latency read data) -------------
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] dly_a;
    logic [15:0] dly_b [3];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
            dly_a <= 16'h0000;
        end else begin
            if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
            dly_a <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[7:0]] : 16'h0000;
        end
    end
    assign bus_a.mem_rdata = dly_a;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(i);
            for (int i = 0; i < 3; i++) dly_b[i] <= 16'h0000;
        end else begin
            if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
            dly_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr[7:0]] : 16'h0000;
            dly_b[1] <= dly_b[0];
            dly_b[2] <= dly_b[1];
        end
    end
    assign bus_b.mem_rdata = dly_b[LAT_B-1];

    // ---------------- reference model for instance A --------------------------
    // A transaction granted in cycle t0 strobes memory in t0+1, pulses done in
    // t0+LAT+2, and the arbiter can grant again from t0+LAT+3.
    int          cyc       = 0;
    bit          m_busy    = 1'b0;
    int          m_t0      = 0;
    bit          m_own_ext = 1'b0;
    bit          m_we      = 1'b0;
    logic [15:0] m_addr    = 16'h0000;
    logic [15:0] m_wdata   = 16'h0000;
    logic [15:0] m_rd      = 16'h0000;
    logic [15:0] x_p_rdata = 16'h0000;
    logic [15:0] x_e_rdata = 16'h0000;
    int          m_starve  = 0;
    bit          x_en, x_pd, x_ed, pipe_win;
    logic [15:0] shadow [256];

    always @(negedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        end
        x_en = m_busy && (cyc == m_t0 + 1);
        x_pd = m_busy && !m_own_ext && (cyc == m_t0 + LAT_A + 2);
        x_ed = m_busy &&  m_own_ext && (cyc == m_t0 + LAT_A + 2);
        if (x_pd && !m_we) x_p_rdata = m_rd;
        if (x_ed && !m_we) x_e_rdata = m_rd;
        check("a_ctl", {59'd0, bus_a.mem_en, bus_a.mem_we, bus_a.p_done, bus_a.e_done, bus_a.stall},
                       {59'd0, x_en, m_we, x_pd, x_ed, bus_a.p_req & ~x_pd});
        check("a_bus", {32'd0, bus_a.mem_addr, bus_a.mem_wdata}, {32'd0, m_addr, m_wdata});
        check("a_rd",  {32'd0, bus_a.p_rdata, bus_a.e_rdata},   {32'd0, x_p_rdata, x_e_rdata});
        if (reset_a) begin
            m_busy = 1'b0; m_starve = 0; m_we = 1'b0;
            m_addr = 16'h0000; m_wdata = 16'h0000;
            x_p_rdata = 16'h0000; x_e_rdata = 16'h0000;
        end else if (m_busy) begin
            if (cyc == m_t0 + LAT_A + 2) m_busy = 1'b0;
        end else if (bus_a.p_req || bus_a.e_req) begin
            pipe_win = bus_a.p_req && !((m_starve == LIM_A) && bus_a.e_req);
            if (pipe_win && bus_a.e_req) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else                         m_starve = 0;
            m_busy = 1'b1; m_t0 = cyc; m_own_ext = !pipe_win;
            m_we    = pipe_win ? bus_a.p_we    : bus_a.e_we;
            m_addr  = pipe_win ? bus_a.p_addr  : bus_a.e_addr;
            m_wdata = pipe_win ? bus_a.p_wdata : bus_a.e_wdata;
            if (m_we) shadow[m_addr[7:0]] = m_wdata;
            else      m_rd = shadow[m_addr[7:0]];
        end else begin
            m_starve = 0;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn_a(input bit ext, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             output int lat, output int en_cnt);
        if (ext) begin bus_a.e_req = 1'b1; bus_a.e_we = we; bus_a.e_addr = addr; bus_a.e_wdata = wdata; end
        else     begin bus_a.p_req = 1'b1; bus_a.p_we = we; bus_a.p_addr = addr; bus_a.p_wdata = wdata; end
        lat = -1; en_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_a.mem_en) en_cnt++;
            if (ext ? bus_a.e_done : bus_a.p_done) begin lat = k; break; end
            next_cycle();
        end
        // request stays high through the done cycle, dropped the cycle after
        next_cycle();
        bus_a.p_req = 1'b0; bus_a.e_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_a.mem_en) en_cnt++;
            next_cycle();
        end
    endtask

    task automatic run_txn_b(input bit ext, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             output int lat, output int en_cnt, output logic [15:0] en_addr);
        if (ext) begin bus_b.e_req = 1'b1; bus_b.e_we = we; bus_b.e_addr = addr; bus_b.e_wdata = wdata; end
        else     begin bus_b.p_req = 1'b1; bus_b.p_we = we; bus_b.p_addr = addr; bus_b.p_wdata = wdata; end
        lat = -1; en_cnt = 0; en_addr = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_b.mem_en) begin en_cnt++; en_addr = bus_b.mem_addr; end
            if (ext ? bus_b.e_done : bus_b.p_done) begin lat = k; break; end
            next_cycle();
        end
        next_cycle();
        bus_b.p_req = 1'b0; bus_b.e_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_b.mem_en) en_cnt++;
            next_cycle();
        end
    endtask

    typedef struct {
        bit          ext;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        vecs [6];
    int          lat, en_cnt;
    logic [15:0] en_addr;
    int          order [$];
    logic [5:0]  exp_order;
    int          got;
    int          pdone_seen;
    bit          pd, ed;

    initial begin
        // owner's rdata after completion: writes leave it unchanged
        vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'hCAFE, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hCAFE};
        vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'hA505};

        reset_a = 1'b1; reset_b = 1'b1; mem_load = 1'b1;
        bus_a.p_req = 1'b0; bus_a.p_we = 1'b0; bus_a.p_addr = 16'h0000; bus_a.p_wdata = 16'h0000;
        bus_a.e_req = 1'b0; bus_a.e_we = 1'b0; bus_a.e_addr = 16'h0000; bus_a.e_wdata = 16'h0000;
        bus_b.p_req = 1'b0; bus_b.p_we = 1'b0; bus_b.p_addr = 16'h0000; bus_b.p_wdata = 16'h0000;
        bus_b.e_req = 1'b0; bus_b.e_we = 1'b0; bus_b.e_addr = 16'h0000; bus_b.e_wdata = 16'h0000;

        // reset values; stall follows p_req even in reset, and no grant happens
        next_cycle();
        @(negedge clk);
        check("rst_a_outs", {bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, bus_a.p_done, bus_a.e_done},
                            64'd0);
        check("rst_a_rdata", {bus_a.p_rdata, bus_a.e_rdata}, 64'd0);
        next_cycle();
        bus_a.p_req = 1'b1;
        @(negedge clk);
        check("rst_stall", {bus_a.stall, bus_a.mem_en}, {1'b1, 1'b0});
        next_cycle();
        bus_a.p_req = 1'b0;
        mem_load = 1'b0; reset_a = 1'b0; reset_b = 1'b0;
        next_cycle();

        // directed single transactions on A
        for (int i = 0; i < 6; i++) begin
            run_txn_a(vecs[i].ext, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, en_cnt);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT_A + 2));
            check($sformatf("vec%0d_en", i), 64'(en_cnt), 64'd1);
            check($sformatf("vec%0d_rd", i), vecs[i].ext ? bus_a.e_rdata : bus_a.p_rdata, vecs[i].exp_rd);
        end

        // contention with both requests held: P P E P P E
        bus_a.p_req = 1'b1; bus_a.p_we = 1'b0; bus_a.p_addr = 16'h0001;
        bus_a.e_req = 1'b1; bus_a.e_we = 1'b0; bus_a.e_addr = 16'h0002;
        order.delete();
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus_a.p_done) order.push_back(0);
            if (bus_a.e_done) order.push_back(1);
            if (order.size() >= 6) break;
            next_cycle();
        end
        next_cycle();
        bus_a.p_req = 1'b0; bus_a.e_req = 1'b0;
        exp_order = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            got = (i < order.size()) ? order[i] : 2;
            check($sformatf("grant%0d", i), 64'(got), 64'(exp_order[i]));
        end
        repeat (3) next_cycle();

        // reset during WAIT: abort without done, outputs back to reset values
        bus_a.p_req = 1'b1; bus_a.p_we = 1'b0; bus_a.p_addr = 16'h0040;
        next_cycle();
        next_cycle();
        reset_a = 1'b1;
        next_cycle();
        reset_a = 1'b0; bus_a.p_req = 1'b0;
        @(negedge clk);
        check("rstw_outs", {bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, bus_a.p_done, bus_a.e_done,
                            bus_a.stall}, 64'd0);
        check("rstw_rdata", {bus_a.p_rdata, bus_a.e_rdata}, 64'd0);
        pdone_seen = 0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            if (bus_a.p_done || bus_a.mem_en) pdone_seen++;
        end
        check("rstw_quiet", 64'(pdone_seen), 64'd0);
        next_cycle();
        run_txn_a(1'b0, 1'b0, 16'h0040, 16'h0000, lat, en_cnt);
        check("rstw_fresh_lat", 64'(lat), 64'(LAT_A + 2));
        check("rstw_fresh_en", 64'(en_cnt), 64'd1);
        check("rstw_fresh_rd", bus_a.p_rdata, 16'hBEEF);

        // instance B, latency 3
        run_txn_b(1'b1, 1'b0, 16'h00FF, 16'h0000, lat, en_cnt, en_addr);
        check("b_ext_lat", 64'(lat), 64'(LAT_B + 2));
        check("b_ext_en", 64'(en_cnt), 64'd1);
        check("b_ext_addr", en_addr, 16'h00FF);
        check("b_ext_rd", {bus_b.e_rdata, bus_b.p_rdata}, {16'h5A5A, 16'h0000});
        run_txn_b(1'b0, 1'b0, 16'h0040, 16'h0000, lat, en_cnt, en_addr);
        check("b_pipe_lat", 64'(lat), 64'(LAT_B + 2));
        check("b_pipe_rd", bus_b.p_rdata, 16'hBEEF);

        // randomized traffic on A, checked every cycle by the model
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            pd = bus_a.p_done; ed = bus_a.e_done;
            next_cycle();
            if (reset_a) reset_a = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset_a = 1'b1;
            if (bus_a.p_req) begin
                if (pd && $urandom_range(0, 1) == 0) begin
                    bus_a.p_we = 1'($urandom_range(0, 1)); bus_a.p_addr = 16'($urandom_range(0, 31));
                    bus_a.p_wdata = 16'($urandom);
                end else if (pd || $urandom_range(0, 99) == 0) begin
                    bus_a.p_req = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus_a.p_req = 1'b1; bus_a.p_we = 1'($urandom_range(0, 1));
                bus_a.p_addr = 16'($urandom_range(0, 31)); bus_a.p_wdata = 16'($urandom);
            end
            if (bus_a.e_req) begin
                if (ed && $urandom_range(0, 1) == 0) begin
                    bus_a.e_we = 1'($urandom_range(0, 1)); bus_a.e_addr = 16'($urandom_range(0, 31));
                    bus_a.e_wdata = 16'($urandom);
                end else if (ed || $urandom_range(0, 99) == 0) begin
                    bus_a.e_req = 1'b0;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                bus_a.e_req = 1'b1; bus_a.e_we = 1'($urandom_range(0, 1));
                bus_a.e_addr = 16'($urandom_range(0, 31)); bus_a.e_wdata = 16'($urandom);
            end
        end
        bus_a.p_req = 1'b0; bus_a.e_req = 1'b0; reset_a = 1'b0;
        repeat (10) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Sequences the single-port 16-bit data memory between two requesters: the pipeline memory stage (downstream of the execute/memory pipeline register) and an external loader/debug port. Fixed priority to the pipeline, with a starvation counter that forces an external grant after a bounded number of consecutive pipeline wins. Generates the pipeline `stall` that freezes the pipeline registers while a pipeline access is outstanding.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LATENCY, 1, cycles from the memory issue cycle to valid `mem_rdata`; legal range 1..7
- STARVE_LIMIT, 4, consecutive pipeline grants with `e_req` pending before the external port is forced; legal range 1..15
- Clock and reset: reset is synchronous and active-high; the clock is `clk`.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- p_req  in  1  pipeline request, level; held with fields until `p_done`
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  ADDR_W  pipeline address (ALU result)
- p_wdata  in  DATA_W  pipeline store data
- p_rdata  out  DATA_W  pipeline load data, valid while `p_done`
- p_done  out  1  one-cycle completion pulse to the pipeline
- stall  out  1  freeze pipeline registers
- e_req, e_we, e_addr, e_wdata  in  1/1/ADDR_W/DATA_W  external port, same protocol as pipeline
- e_rdata  out  DATA_W  external read data, valid while `e_done`
- e_done  out  1  external completion pulse
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, MEM_LATENCY cycles after issue

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if either request is high, select the winner and latch owner, `we`, `addr`, `wdata` into internal registers, then go to ISSUE. Otherwise stay.
- Winner selection: the pipeline wins when `p_req` is high, unless `starve_cnt == STARVE_LIMIT` and `e_req` is high. The external port wins when it is the only requester.
- `starve_cnt`: increments (saturating) on each pipeline grant while `e_req` is high. Clears on an external grant, or in any IDLE cycle where `e_req` is low.
- ISSUE: `mem_en=1`; `mem_we/addr/wdata` come from the latched fields. Load the latency counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter. At 0, capture `mem_rdata` into the owner's rdata register (for reads only; writes leave it unchanged) and go to DONE.
- DONE: pulse the owner's `done`, then go to IDLE. Requests are ignored in DONE so a held request is not re-granted.
- `stall = p_req & ~p_done` (combinational).
- If the owner drops `req` mid-transaction, the arbiter still completes it and pulses `done`. This is a protocol violation, but the arbiter tolerates it.
- `mem_en` is low in every state except ISSUE. `mem_addr/mem_wdata/mem_we` hold their latched values otherwise.

## Timing
- Request seen in IDLE at cycle T0 → `mem_en` at T0+1 → `done` at T0+MEM_LATENCY+2.
- Back-to-back throughput: one transaction per MEM_LATENCY+3 cycles. A new request is sampled no earlier than the cycle after DONE.
- Reset values:
  - state IDLE
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`
  - `p_done=0`, `e_done=0`
  - `p_rdata=0`, `e_rdata=0`
  - `starve_cnt=0`
  - `stall` follows `p_req`
- Reset mid-transaction: abort to IDLE on the next edge with no `done` pulse. A write already strobed in ISSUE is not undone.
- Simultaneous `p_req` and `e_req` at the limit: the external port is granted and `starve_cnt` clears in the same edge.

## Structure
- Shared package `cpu_mem_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE}
  - `arb_owner_t` enum {OWN_PIPE, OWN_EXT}
  - default widths `MEM_ADDR_W`/`MEM_DATA_W` = 16
- Single module `data_memory_arbiter`; no sub-module. The starvation counter and latency counter are inline registers.

## Test plan
- Pipeline read alone, MEM_LATENCY=1: `p_req=1, p_we=0, p_addr=0x0040`, memory returns 0xBEEF → `mem_en` at T1, `p_done` and `p_rdata=0xBEEF` at T3, `stall` high T0–T2.
- Pipeline write: `p_addr=0x0010`, `p_wdata=0x1234` → single `mem_en`/`mem_we` cycle with those values, `p_done` at T3, `p_rdata` unchanged.
- Contention, STARVE_LIMIT=2: both requests held continuously → grant order PIPE, PIPE, EXT, PIPE, PIPE, EXT; `e_done` on the 3rd and 6th transactions.
- MEM_LATENCY=3: external read of 0x00FF returning 0x5A5A → `e_done` exactly 5 cycles after the request is seen, `e_rdata=0x5A5A`; `mem_en` high exactly one cycle.
- Held request: `p_req` kept high after `p_done` for one cycle, then dropped → no second `mem_en`.
- Reset asserted during WAIT → next cycle IDLE, no `done` pulse, all outputs at reset values; a fresh request afterward completes normally.
